// File: rtl/spi_mram_responder.sv
// rtl/spi_mram_responder.sv - SPI mode-3 MRAM device model (WREN/WRDI/RDSR/READ/WRITE)
// SPI pins are oversampled in the clk_i domain, so SCK phases must span several clk_i cycles.
module spi_mram_responder #(
  parameter int ADDRESSBITS = 16,
  parameter int DEPTHBITS   = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic spiCs_i,
  input  logic spiClk_i,
  input  logic spiMosi_i,
  output logic spiMiso_o,
  output logic wel_o,
  output logic busy_o
);

  localparam int IW = (ADDRESSBITS > 8) ? ADDRESSBITS : 8;
  localparam int CW = $clog2(IW + 1);
  localparam logic [CW-1:0] BYTE_BITS = CW'(8);
  localparam logic [CW-1:0] ADDR_BITS = CW'(ADDRESSBITS);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_WREN, S_WRDI, S_RDSR, S_IGNORE, S_WAITCS
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             cs_sync_q, cs_sync_d;
  logic [2:0]             sck_sync_q, sck_sync_d;
  logic [1:0]             mosi_sync_q, mosi_sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          in_q, in_d;
  logic [7:0]             out_q, out_d;
  logic [ADDRESSBITS-1:0] addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic                   permit_q, permit_d;
  logic                   wel_q, wel_d;
  logic                   miso_q, miso_d;
  logic                   load_q, load_d;
  logic                   wr_pend_q, wr_pend_d;

  logic [7:0]             mem [0:(1<<DEPTHBITS)-1];
  logic [7:0]             rd_byte;
  logic [7:0]             status;
  logic                   cs_fall, cs_rise, cs_low, sck_rise, mosi;
  logic [IW-1:0]          in_new;
  logic [CW-1:0]          cnt_new;
  logic                   wr_en;

  assign cs_low   = ~cs_sync_q[1];
  assign cs_fall  = cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise  = ~cs_sync_q[2] & cs_sync_q[1];
  assign sck_rise = ~sck_sync_q[2] & sck_sync_q[1];
  assign mosi     = mosi_sync_q[1];
  assign in_new   = {in_q[IW-2:0], mosi};
  assign cnt_new  = cnt_q + 1'b1;
  assign status   = {6'b0, wel_q, 1'b0};
  assign rd_byte  = mem[addr_q[DEPTHBITS-1:0]];
  assign wr_en    = wr_pend_q & permit_q;

  always_ff @(posedge clk_i) begin
    cs_sync_q   <= cs_sync_d;
    sck_sync_q  <= sck_sync_d;
    mosi_sync_q <= mosi_sync_d;
    in_q        <= in_d;
    out_q       <= out_d;
    addr_q      <= addr_d;
    rw_q        <= rw_d;
    permit_q    <= permit_d;
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wel_q     <= 1'b0;
      miso_q    <= 1'b0;
      load_q    <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wel_q     <= wel_d;
      miso_q    <= miso_d;
      load_q    <= load_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[addr_q[DEPTHBITS-1:0]] <= in_q[7:0];
  end

  always_comb begin
    cs_sync_d   = {cs_sync_q[1:0], spiCs_i};
    sck_sync_d  = {sck_sync_q[1:0], spiClk_i};
    mosi_sync_d = {mosi_sync_q[0], spiMosi_i};
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_d      = in_q;
    out_d     = out_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    permit_d  = permit_q;
    wel_d     = wel_q;
    miso_d    = miso_q;
    load_d    = 1'b0;
    wr_pend_d = 1'b0;

    if (wr_pend_q) addr_d = addr_q + 1'b1;
    if (load_q && state_q == S_RDATA) begin
      out_d  = rd_byte;
      miso_d = rd_byte[7];
    end

    if (cs_rise) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      case (state_q)
        S_WREN:  wel_d = 1'b1;
        S_WRDI:  wel_d = 1'b0;
        S_WDATA: wel_d = 1'b0;
        S_ADDR:  if (rw_q) wel_d = 1'b0;
        default: ;
      endcase
    end else begin
      case (state_q)
        // CS already low in IDLE without a fall edge means reset landed mid-frame.
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end else if (cs_low) begin
            state_d = S_WAITCS;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            in_d  = in_new;
            cnt_d = cnt_new;
            if (cnt_new == BYTE_BITS) begin
              cnt_d = '0;
              case (in_new[7:0])
                8'h03: begin state_d = S_ADDR; rw_d = 1'b0; end
                8'h02: begin state_d = S_ADDR; rw_d = 1'b1; permit_d = wel_q; end
                8'h06: state_d = S_WREN;
                8'h04: state_d = S_WRDI;
                8'h05: begin state_d = S_RDSR; out_d = status; miso_d = status[7]; end
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            in_d  = in_new;
            cnt_d = cnt_new;
            if (cnt_new == ADDR_BITS) begin
              cnt_d  = '0;
              addr_d = in_new[ADDRESSBITS-1:0];
              if (rw_q) begin
                state_d = S_WDATA;
              end else begin
                state_d = S_RDATA;
                load_d  = 1'b1;
              end
            end
          end
        end
        S_RDATA, S_RDSR: begin
          if (sck_rise) begin
            if (cnt_new == BYTE_BITS) begin
              cnt_d = '0;
              if (state_q == S_RDATA) begin
                addr_d = addr_q + 1'b1;
                load_d = 1'b1;
              end else begin
                out_d  = status;
                miso_d = status[7];
              end
            end else begin
              cnt_d  = cnt_new;
              out_d  = {out_q[6:0], 1'b0};
              miso_d = out_q[6];
            end
          end
        end
        S_WDATA: begin
          if (sck_rise) begin
            in_d  = in_new;
            cnt_d = cnt_new;
            if (cnt_new == BYTE_BITS) begin
              cnt_d     = '0;
              wr_pend_d = 1'b1;
            end
          end
        end
        // Any bit past the opcode disqualifies the latch update.
        S_WREN, S_WRDI: if (sck_rise) state_d = S_IGNORE;
        default: ;
      endcase
    end
  end

  always_comb begin
    spiMiso_o = miso_q;
    wel_o     = wel_q;
    busy_o    = cs_low;
  end

endmodule
